crc_serial_framer: RTL and testbench

- Upstream neighbour of the serial CRC stage.
- Accepts parallel payload words over a valid/ready handshake and serializes each word LSB-first onto DATA/ACTIVE to feed the CRC stage.
- Then collects the CRC stage's serial CRC bits and emits one merged serial frame: payload bits followed by CRC bits.
- Sequences the CRC stage's per-frame clear between frames.

---
 rtl/crc_serial_framer.sv | 136 +++++++++++++
 tb/tb_crc_serial_framer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/crc_serial_framer.sv
// Serializes payload words LSB-first toward the serial CRC stage, then merges the
// returned CRC bits behind the payload into a single TX frame and clears the stage.
module crc_serial_framer #(
    parameter int DATA_WD    = 8,
    parameter int CRC_WD     = 8,
    parameter int CRC_LAT    = 1,
    parameter int GAP_CYCLES = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [DATA_WD-1:0] IN_DATA,
    input  logic               IN_VALID,
    output logic               IN_READY,
    output logic               SER_DATA,
    output logic               SER_ACTIVE,
    input  logic               CRC_IN,
    output logic               CRC_CLR,
    output logic               TX_BIT,
    output logic               TX_VALID,
    output logic               FRAME_DONE
);

    localparam int MAX_DC  = (DATA_WD > CRC_WD) ? DATA_WD : CRC_WD;
    localparam int MAX_DCG = (MAX_DC > GAP_CYCLES) ? MAX_DC : GAP_CYCLES;
    localparam int MAX_ALL = (MAX_DCG > CRC_LAT) ? MAX_DCG : CRC_LAT;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WD - 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(CRC_LAT - 1);
    localparam logic [CNT_W-1:0] LAST_CRC  = CNT_W'(CRC_WD - 1);
    localparam logic [CNT_W-1:0] LAST_GAP  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {IDLE, SHIFT, WAIT, CRC, GAP} state_t;

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]   crc_cnt;
    logic [CNT_W-1:0]   gap_cnt;
    logic [DATA_WD-1:0] shreg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            wait_cnt   <= '0;
            crc_cnt    <= '0;
            gap_cnt    <= '0;
            shreg      <= '0;
            IN_READY   <= 1'b0;
            SER_DATA   <= 1'b0;
            SER_ACTIVE <= 1'b0;
            CRC_CLR    <= 1'b1;
            TX_BIT     <= 1'b0;
            TX_VALID   <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            CRC_CLR    <= 1'b0;
            FRAME_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (IN_READY && IN_VALID) begin
                        // Bit 0 goes out immediately; the register keeps the remaining bits.
                        shreg      <= {1'b0, IN_DATA[DATA_WD-1:1]};
                        SER_DATA   <= IN_DATA[0];
                        TX_BIT     <= IN_DATA[0];
                        SER_ACTIVE <= 1'b1;
                        TX_VALID   <= 1'b1;
                        IN_READY   <= 1'b0;
                        bit_cnt    <= '0;
                        state      <= SHIFT;
                    end else begin
                        IN_READY <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bit_cnt == LAST_BIT) begin
                        SER_ACTIVE <= 1'b0;
                        SER_DATA   <= 1'b0;
                        if (CRC_LAT == 0) begin
                            TX_BIT   <= CRC_IN;
                            TX_VALID <= 1'b1;
                            crc_cnt  <= '0;
                            state    <= CRC;
                        end else begin
                            TX_BIT   <= 1'b0;
                            TX_VALID <= 1'b0;
                            wait_cnt <= '0;
                            state    <= WAIT;
                        end
                    end else begin
                        bit_cnt  <= bit_cnt + CNT_ONE;
                        SER_DATA <= shreg[0];
                        TX_BIT   <= shreg[0];
                        shreg    <= shreg >> 1;
                    end
                end
                WAIT: begin
                    // The last wait cycle already carries the first CRC bit on CRC_IN.
                    if (wait_cnt == LAST_WAIT) begin
                        TX_BIT   <= CRC_IN;
                        TX_VALID <= 1'b1;
                        crc_cnt  <= '0;
                        state    <= CRC;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                    end
                end
                CRC: begin
                    if (crc_cnt == LAST_CRC) begin
                        TX_BIT     <= 1'b0;
                        TX_VALID   <= 1'b0;
                        CRC_CLR    <= 1'b1;
                        FRAME_DONE <= 1'b1;
                        gap_cnt    <= '0;
                        state      <= GAP;
                    end else begin
                        crc_cnt <= crc_cnt + CNT_ONE;
                        TX_BIT  <= CRC_IN;
                    end
                end
                GAP: begin
                    if (gap_cnt == LAST_GAP) begin
                        IN_READY <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_serial_framer.sv
// Bench for crc_serial_framer: default instance driven against an LFSR model of the CRC
// stage, plus a 16/16/0/1 instance fed random CRC bits.
module tb_crc_serial_framer;

    localparam int D = 8, L = 1, C = 8, G = 2;
    localparam int P = 1 + D + L + C + G;
    localparam logic [7:0] SEED = 8'hD8, TAPS = 8'h44;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, in_ready, ser_data, ser_active, crc_in, crc_clr;
    logic       tx_bit, tx_valid, frame_done;
    logic [7:0] in_data;

    logic        in_valid16, in_ready16, ser_data16, ser_active16, crc_in16, crc_clr16;
    logic        tx_bit16, tx_valid16, frame_done16;
    logic [15:0] in_data16;

    crc_serial_framer dut (
        .CLK(clk), .RST(rst), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
        .SER_DATA(ser_data), .SER_ACTIVE(ser_active), .CRC_IN(crc_in), .CRC_CLR(crc_clr),
        .TX_BIT(tx_bit), .TX_VALID(tx_valid), .FRAME_DONE(frame_done)
    );

    crc_serial_framer #(.DATA_WD(16), .CRC_WD(16), .CRC_LAT(0), .GAP_CYCLES(1)) dut16 (
        .CLK(clk), .RST(rst), .IN_DATA(in_data16), .IN_VALID(in_valid16), .IN_READY(in_ready16),
        .SER_DATA(ser_data16), .SER_ACTIVE(ser_active16), .CRC_IN(crc_in16), .CRC_CLR(crc_clr16),
        .TX_BIT(tx_bit16), .TX_VALID(tx_valid16), .FRAME_DONE(frame_done16)
    );

    logic [6:0] ov, ov16;
    assign ov   = {in_ready, ser_active, ser_data, tx_valid, tx_bit, crc_clr, frame_done};
    assign ov16 = {in_ready16, ser_active16, ser_data16, tx_valid16, tx_bit16, crc_clr16, frame_done16};

    // CRC stage model: cleared by CRC_CLR, absorbs bits while ACTIVE, then shifts out LSB-first.
    logic [7:0] lfsr;
    logic       armed;
    always @(posedge clk) begin
        if (crc_clr) begin
            lfsr  <= SEED;
            armed <= 1'b0;
        end else if (ser_active) begin
            lfsr  <= (lfsr >> 1) ^ (((lfsr[0] ^ ser_data) == 1'b1) ? TAPS : 8'h00);
            armed <= 1'b1;
        end else if (armed) begin
            lfsr <= lfsr >> 1;
        end
    end
    assign crc_in = lfsr[0];

    int cyc = 0, n_done = 0, n_done16 = 0;
    int n_checks = 0, n_pass = 0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        n_done   <= n_done + int'(frame_done);
        n_done16 <= n_done16 + int'(frame_done16);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] crc_ref(input logic [7:0] w);
        int r, fb;
        r = SEED;
        for (int i = 0; i < 8; i++) begin
            fb = (r % 2) ^ int'(w[i]);
            r  = r / 2;
            if (fb != 0) r = r ^ int'(TAPS);
        end
        return 8'(r);
    endfunction

    function automatic logic [6:0] exp_main(input int k, input logic [7:0] w, input logic [7:0] c);
        logic act, sd, tv, tb, ev;
        act = (k >= 1 && k <= D);
        sd  = 1'b0;
        tb  = 1'b0;
        if (act) begin
            sd = w[k-1];
            tb = w[k-1];
        end
        tv = act;
        if (k > D + L && k <= D + L + C) begin
            tv = 1'b1;
            tb = c[k-D-L-1];
        end
        ev = (k == D + L + C + 1);
        return {k == P, act, sd, tv, tb, ev, ev};
    endfunction

    task automatic start(input logic [7:0] w, input string tag, output int hs);
        int g;
        in_data  = w;
        in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 60) begin
            @(negedge clk);
            g++;
        end
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        hs = -1;
        if (in_ready) begin
            @(posedge clk);
            #1;
            hs = cyc;
        end
    endtask

    task automatic frame(input logic [7:0] w, input int nk, input logic nv, input logic [7:0] nd,
                         input string tag, output int hs);
        logic [7:0] c;
        c = crc_ref(w);
        start(w, tag, hs);
        if (hs < 0) begin
            in_valid = 1'b0;
            return;
        end
        if (nk == 0) begin
            in_valid = nv;
            in_data  = nd;
        end
        for (int k = 1; k <= P; k++) begin
            @(negedge clk);
            chk($sformatf("%s_k%0d", tag, k), 32'(ov), 32'(exp_main(k, w, c)));
            if (k == nk) begin
                in_valid = nv;
                in_data  = nd;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int cin [0:40];

    initial begin
        int h1, h2, d0;
        logic [7:0]  aw, bw;
        logic [15:0] w16;
        logic        act, tv, tb;

        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        in_valid16 = 1'b0; in_data16 = '0; crc_in16 = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset", 32'(ov), 32'h02);
            chk("reset16", 32'(ov16), 32'h02);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset", 32'(ov), 32'h40);
        chk("post_reset16", 32'(ov16), 32'h40);

        frame(8'hA5, 0, 1'b0, 8'h00, "a5", h1);

        d0 = n_done;
        frame(8'h00, 0, 1'b1, 8'hFF, "b2b0", h1);
        frame(8'hFF, 0, 1'b0, 8'h00, "b2b1", h2);
        chk("b2b_period", 32'(h2 - h1), 32'd20);
        chk("b2b_done_count", 32'(n_done - d0), 32'd2);

        aw = 8'($urandom);
        bw = 8'($urandom);
        frame(aw, 3, 1'b1, bw, "bp_a", h1);
        frame(bw, 0, 1'b0, 8'h00, "bp_b", h2);
        chk("bp_period", 32'(h2 - h1), 32'd20);

        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            frame(8'($urandom), 0, 1'b0, 8'h00, $sformatf("rnd%0d", r), h1);
        end

        // Abort mid-frame while bit 4 is on the wire.
        d0 = n_done;
        start(8'h96, "mid", h1);
        in_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("mid_k%0d", k), 32'(ov), 32'(exp_main(k, 8'h96, 8'h00)));
        end
        rst = 1'b1;
        @(negedge clk);
        chk("mid_reset", 32'(ov), 32'h02);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_release", 32'(ov), 32'h40);
        chk("mid_no_done", 32'(n_done - d0), 32'd0);
        frame(8'h3C, 0, 1'b0, 8'h00, "after_rst", h1);

        // 16/16/0/1 instance with random CRC bits.
        w16 = 16'($urandom);
        in_data16  = w16;
        in_valid16 = 1'b1;
        chk("sw_ready", 32'(in_ready16), 32'd1);
        d0 = n_done16;
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            act = (k <= 16);
            tv  = (k <= 32);
            tb  = act ? w16[k-1] : ((k <= 32) ? cin[k-1][0] : 1'b0);
            chk($sformatf("sw_k%0d", k), 32'(ov16),
                32'({k == 34, act, act & w16[(k-1) % 16], tv, tb, k == 33, k == 33}));
            crc_in16 = 1'($urandom);
            cin[k]   = int'(crc_in16);
        end
        chk("sw_done_count", 32'(n_done16 - d0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
